// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and opcode-field helpers.
// The decoder reuses the opcode constants and extract function.
package cpu_pkg;

   localparam int unsigned INS_WORD_SIZE = 8;
   localparam int unsigned OPC_SIZE      = 4;
   localparam logic [OPC_SIZE-1:0] HALT_OP = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      HALTED
   } fetch_state_t;

   function automatic logic [OPC_SIZE-1:0] opcode_of(input logic [INS_WORD_SIZE-1:0] ins);
      return ins[INS_WORD_SIZE-1 -: OPC_SIZE];
   endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives ins_memory's address and
// hands fetched words to decode over a valid/ready handshake; stops on HALT.
module fetch_controller
   import cpu_pkg::*;
#(
   parameter int unsigned          WORD_SIZE  = 8,
   parameter int unsigned          INDEX_SIZE = 4,
   parameter int unsigned          OPC_SIZE   = cpu_pkg::OPC_SIZE,
   parameter logic [OPC_SIZE-1:0]  HALT_OP    = cpu_pkg::HALT_OP
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WORD_SIZE-1:0]  ins_val,
   output logic [INDEX_SIZE-1:0] prog_count,
   output logic [WORD_SIZE-1:0]  ir_out,
   output logic [INDEX_SIZE-1:0] ir_pc,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   input  logic                  redirect_valid,
   input  logic [INDEX_SIZE-1:0] redirect_pc,
   output logic                  halted,
   output logic                  busy
);

   fetch_state_t          state;
   logic [INDEX_SIZE-1:0] pc;
   logic [OPC_SIZE-1:0]   opcode;
   logic                  load;

   assign prog_count = pc;
   assign opcode     = ins_val[WORD_SIZE-1 -: OPC_SIZE];
   assign load       = (state == RUN) && (!ir_valid || ir_ready) && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         ir_out   <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end

            RUN, DRAIN: begin
               // Redirect outranks both fetch and halt completion; an
               // instruction accepted in the same cycle is simply dropped.
               if (redirect_valid) begin
                  pc       <= redirect_pc;
                  ir_valid <= 1'b0;
                  state    <= RUN;
                  busy     <= 1'b1;
               end else if (state == RUN) begin
                  if (load) begin
                     ir_out   <= ins_val;
                     ir_pc    <= pc;
                     ir_valid <= 1'b1;
                     if (opcode == HALT_OP) begin
                        state <= DRAIN;
                     end else begin
                        pc <= pc + INDEX_SIZE'(1);
                     end
                  end
               end else if (ir_valid && ir_ready) begin
                  ir_valid <= 1'b0;
                  halted   <= 1'b1;
                  busy     <= 1'b0;
                  state    <= HALTED;
               end
            end

            HALTED: begin
               if (start) begin
                  pc     <= '0;
                  halted <= 1'b0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a behavioural ins_memory beside it.
module tb_fetch_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] ins_val;
   logic [3:0] prog_count;
   logic [7:0] ir_out;
   logic [3:0] ir_pc;
   logic       ir_valid;
   logic       ir_ready;
   logic       redirect_valid;
   logic [3:0] redirect_pc;
   logic       halted;
   logic       busy;

   logic [7:0] mem [16];

   typedef struct packed {
      logic [7:0] ins;
      logic [3:0] pc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic [7:0] prog [12] = '{8'hD8, 8'h51, 8'hD5, 8'h52, 8'h41, 8'h12,
                             8'h21, 8'h32, 8'hB0, 8'hC0, 8'h00, 8'hF0};

   fetch_controller #(
      .WORD_SIZE  (8),
      .INDEX_SIZE (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .ins_val        (ins_val),
      .prog_count     (prog_count),
      .ir_out         (ir_out),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .busy           (busy)
   );

   assign ins_val = mem[prog_count];

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_default();
      for (int i = 0; i < 16; i++) mem[i] = (i < 12) ? prog[i] : 8'h00;
   endtask

   task automatic push_prog(input int from, input int to);
      for (int i = from; i <= to; i++) sb.push_back({prog[i], 4'(i)});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halted && n < 60) begin
         step();
         n++;
      end
      check({tag, "_halted"}, halted, 1);
      check({tag, "_pc_hold"}, prog_count, 11);
      check({tag, "_valid_clr"}, ir_valid, 0);
      check({tag, "_busy_clr"}, busy, 0);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic wait_ir_pc(input string tag, input int target);
      int n = 0;
      while (!(ir_valid && ir_pc == 4'(target)) && n < 30) begin
         step();
         n++;
      end
      check({tag, "_reached"}, (ir_valid && ir_pc == 4'(target)) ? 1 : 0, 1);
   endtask

   // Monitor: every accepted instruction must match the next expectation.
   always @(negedge clk) begin
      if (rst_n && ir_valid && ir_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_accept: got ir_out=0x%0h ir_pc=%0d expected none", ir_out, ir_pc);
         end else begin
            check("sb_ir_out", ir_out, sb[0].ins);
            check("sb_ir_pc", ir_pc, sb[0].pc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ir_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      load_default();
      #2;
      check("rst_pc", prog_count, 0);
      check("rst_ir_out", ir_out, 0);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_busy", busy, 0);
      #10 rst_n = 1'b1;
      step();

      // Full default program with ir_ready held high
      push_prog(0, 11);
      ir_ready = 1'b1;
      pulse_start();
      check("start_busy", busy, 1);
      check("start_no_valid_yet", ir_valid, 0);
      step();
      check("first_valid", ir_valid, 1);
      check("first_ins", ir_out, 8'hD8);
      run_to_halt("prog");
      check("halt_ir_out_hold", ir_out, 8'hF0);

      // Redirect while HALTED is ignored
      redirect_valid = 1'b1;
      redirect_pc = 4'd3;
      step();
      step();
      redirect_valid = 1'b0;
      check("halted_redir_pc", prog_count, 11);
      check("halted_redir_halted", halted, 1);
      check("halted_redir_valid", ir_valid, 0);

      // Restart with backpressure on the third instruction
      push_prog(0, 11);
      pulse_start();
      check("restart_halted_clr", halted, 0);
      wait_ir_pc("bp", 2);
      ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_ir_out", ir_out, 8'hD5);
         check("bp_ir_pc", ir_pc, 2);
         check("bp_pc", prog_count, 3);
      end
      ir_ready = 1'b1;
      run_to_halt("bp");

      // Redirect to 9 while ir_pc=4 is held back
      push_prog(0, 3);
      push_prog(9, 11);
      pulse_start();
      wait_ir_pc("rd", 4);
      ir_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 4'd9;
      step();
      redirect_valid = 1'b0;
      check("rd_flush", ir_valid, 0);
      check("rd_pc", prog_count, 9);
      ir_ready = 1'b1;
      step();
      check("rd_first_valid", ir_valid, 1);
      check("rd_first_ins", ir_out, 8'hC0);
      check("rd_first_pc", ir_pc, 9);
      run_to_halt("rd");

      // Asynchronous reset mid-run with an instruction pending
      ir_ready = 1'b0;
      pulse_start();
      step();
      check("ar_pre_valid", ir_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      check("ar_valid", ir_valid, 0);
      check("ar_pc", prog_count, 0);
      check("ar_ir_out", ir_out, 0);
      check("ar_ir_pc", ir_pc, 0);
      check("ar_busy", busy, 0);
      check("ar_halted", halted, 0);
      @(negedge clk);
      rst_n = 1'b1;
      push_prog(0, 11);
      ir_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      run_to_halt("ar");

      // PC wrap with a HALT-free program
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) sb.push_back({8'h10 + 8'(k % 16), 4'(k % 16)});
      ir_ready = 1'b1;
      pulse_start();
      begin
         int n = 0;
         while (sb.size() > 0 && n < 40) begin
            step();
            check("wrap_busy", busy, 1);
            n++;
         end
      end
      ir_ready = 1'b0;
      check("wrap_sb_empty", sb.size(), 0);
      check("wrap_next_valid", ir_valid, 1);
      check("wrap_next_pc", ir_pc, 4);
      check("wrap_no_halt", halted, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 16-entry instruction memory (`ins_memory`).
- Owns the program counter and drives `prog_count`. Captures `ins_val` into an instruction register.
- Presents that register to the decode/execute stage over a valid/ready handshake.
- Handles control-flow redirects and halts on the HALT opcode.

Parameters:
- WORD_SIZE, 8, instruction width in bits (matches `ins_memory` `word_size`).
- INDEX_SIZE, 4, PC / address width (matches `ins_memory` `index_size`).
- OPC_SIZE, 4, opcode field width, taken from bits [WORD_SIZE-1 -: OPC_SIZE].
- HALT_OP, 4'b1111, opcode value that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching (from IDLE) or restart at address 0 (from HALTED).
- ins_val  in  WORD_SIZE  combinational read data from `ins_memory`.
- prog_count  out  INDEX_SIZE  address to `ins_memory`; equals the PC register.
- ir_out  out  WORD_SIZE  instruction register contents.
- ir_pc  out  INDEX_SIZE  address the `ir_out` instruction was fetched from.
- ir_valid  out  1  `ir_out` holds an instruction not yet accepted.
- ir_ready  in  1  consumer accepts `ir_out` this cycle when `ir_valid`=1.
- redirect_valid  in  1  replace the PC (branch/jump resolved downstream).
- redirect_pc  in  INDEX_SIZE  new PC value.
- halted  out  1  HALT instruction has been accepted; fetch stopped.
- busy  out  1  state is RUN or DRAIN.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, pc=0, ir_out=0, ir_pc=0, ir_valid=0, halted=0, busy=0.
- All other state changes occur on the rising edge of clk.
- prog_count = pc at all times; memory read is combinational, so ins_val corresponds to the current pc.
- load = (state==RUN) && (!ir_valid || ir_ready) && !redirect_valid.
- IDLE:
  - start=1 -> RUN; pc unchanged.
  - redirect_valid is ignored.
- RUN, on load:
  - ir_out<=ins_val, ir_pc<=pc, ir_valid<=1.
  - If the opcode of ins_val == HALT_OP: pc holds, state -> DRAIN.
  - Otherwise pc<=pc+1, wrapping from 15 to 0 with no flag.
- RUN, no load (backpressure, ir_valid=1 && ir_ready=0): pc, ir_out and ir_pc all hold.
- DRAIN:
  - Waits for ir_valid && ir_ready on the HALT instruction, then ir_valid<=0, halted<=1, state -> HALTED.
  - No further fetch occurs.
- HALTED:
  - halted stays 1 and prog_count holds.
  - start=1 -> pc<=0, halted<=0, state -> RUN.
  - redirect_valid is ignored.
- Redirect (RUN or DRAIN only) has priority over load:
  - pc<=redirect_pc, ir_valid<=0 (flush), state -> RUN.
  - If ir_ready=1 in the same cycle, the current ir_out counts as consumed; it is not re-presented.
  - A redirect during DRAIN cancels the halt.
- Latency:
  - start sampled at edge N -> RUN after N.
  - First ir_valid=1 after edge N+1, with ir_out=ins[0].
  - Thereafter throughput is one instruction per cycle while ir_ready=1.
  - After a redirect at edge N, the first new instruction is valid after edge N+1.
- start asserted while in RUN or DRAIN is ignored.
- ir_out holds its value when ir_valid=0. The consumer must not use ir_out when ir_valid=0.

Decomposition:
- Shared package `cpu_pkg`:
  - fetch state enum {IDLE, RUN, DRAIN, HALTED}.
  - HALT_OP and OPC_SIZE constants.
  - Opcode-extract function. The decoder will reuse these opcode definitions.
- Single module; no sub-module is warranted.
- `ins_memory` is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset, start pulse, ir_ready=1 constant, default program -> ir_out sequence:
  - 0xD8,0x51,0xD5,0x52,0x41,0x12,0x21,0x32,0xB0,0xC0,0x00,0xF0.
  - ir_pc 0..11 in order.
  - halted=1 the cycle after 0xF0 is accepted; prog_count stays 11; ir_valid=0.
- Backpressure: drop ir_ready for 3 cycles while ir_out=0xD5 (ir_pc=2) -> ir_out, ir_pc and prog_count=3 hold stable; resume -> next ir_out 0x52, no instruction skipped or duplicated.
- Redirect: while ir_pc=4 is valid, pulse redirect_valid with redirect_pc=9 and ir_ready=0 -> ir_valid=0 next cycle, then ir_out=0xC0 with ir_pc=9, then 0x00, then 0xF0.
- Wrap: memory loaded with no HALT opcode -> after ir_pc=15 the next ir_pc is 0; busy stays 1.
- Reset mid-operation: drive rst_n=0 asynchronously (between clock edges) while in RUN with ir_valid=1 -> all outputs go to their reset values immediately, before any clock edge; a subsequent start fetches from address 0.
- Restart: in HALTED, pulse start -> halted=0, then ir_out=0xD8 with ir_pc=0. Also: redirect_valid with redirect_pc=3 asserted in HALTED with no start -> ignored (prog_count unchanged, halted stays 1, ir_valid stays 0).
